// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source: mode encodings,
// RGB888 width and the colour-bar palette.
package vga_pkg;

  localparam int RGB_W = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_GRID = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_BOX  = 2'd3
  } mode_t;

  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_BLACK = 24'h000000;
  localparam rgb_t RGB_RED   = 24'hFF0000;
  localparam rgb_t RGB_BLUE  = 24'h0000FF;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: one step per Frame_Start on each axis, direction
// flips when the box touches either edge of the active area.
module vga_box_mover #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 64
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Step,
  output logic [11:0] Box_X,
  output logic [11:0] Box_Y
);

  logic [11:0] r_pos [2];
  logic [1:0]  r_dir;
  logic [11:0] w_step [2];
  logic [11:0] w_lim  [2];

  // Axis 0 is X, axis 1 is Y; both share the same bounce rule.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign w_lim[gi]  = (gi == 0) ? 12'(H_ACTIVE - BOX_SIZE) : 12'(V_ACTIVE - BOX_SIZE);
    assign w_step[gi] = r_dir[gi] ? r_pos[gi] + 12'd1 : r_pos[gi] - 12'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pos[0] <= '0;
      r_pos[1] <= '0;
      r_dir    <= 2'b11;
    end else if (Step) begin
      for (int i = 0; i < 2; i++) begin
        r_pos[i] <= w_step[i];
        if (w_step[i] == w_lim[i])
          r_dir[i] <= 1'b0;
        else if (w_step[i] == 12'd0)
          r_dir[i] <= 1'b1;
      end
    end
  end

  assign Box_X = r_pos[0];
  assign Box_Y = r_pos[1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: mode sequencer plus a registered pixel mux that
// answers each Data_Req one clock later.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int BOX_SIZE        = 64,
  parameter int GRID_PITCH      = 32,
  parameter int FRAMES_PER_MODE = 120
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Frame_Start,
  input  logic        Data_Req,
  input  logic [11:0] H_Addr,
  input  logic [11:0] V_Addr,
  input  logic        Auto_En,
  input  logic        Mode_Next,
  output logic [23:0] Disp_Data,
  output logic [1:0]  Mode
);

  localparam int          BAR_W     = H_ACTIVE / 8;
  localparam int          CNT_W     = $clog2(FRAMES_PER_MODE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MODE - 1);
  localparam logic [11:0] GRID_MASK = 12'(GRID_PITCH - 1);

  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  rgb_t             r_disp;

  logic        w_auto_hit;
  logic        w_advance;
  logic [11:0] w_box_x;
  logic [11:0] w_box_y;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Step    (Frame_Start),
    .Box_X   (w_box_x),
    .Box_Y   (w_box_y)
  );

  // Only meaningful at a Frame_Start, which is the only place these are used.
  assign w_auto_hit = Auto_En && (r_cnt == CNT_LAST);
  assign w_advance  = r_pend || Mode_Next || w_auto_hit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mode <= MODE_BARS;
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (Frame_Start) begin
      r_pend <= 1'b0;
      if (w_advance) begin
        r_mode <= mode_t'(r_mode + 2'd1);
        r_cnt  <= '0;
      end else if (Auto_En) begin
        r_cnt  <= r_cnt + 1'b1;
      end else begin
        r_cnt  <= '0;
      end
    end else begin
      if (Mode_Next)
        r_pend <= 1'b1;
      if (!Auto_En)
        r_cnt  <= '0;
    end
  end

  // Bar index from constant edge comparators instead of a divider.
  logic [7:1] w_bar_ge;
  logic [2:0] w_bar_idx;

  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    assign w_bar_ge[gi] = (H_Addr >= 12'(gi * BAR_W));
  end

  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (w_bar_ge[i])
        w_bar_idx = 3'(i);
  end

  logic w_grid_on;
  logic w_in_box;
  rgb_t w_pix;

  assign w_grid_on = ((H_Addr & GRID_MASK) == 12'd0) || ((V_Addr & GRID_MASK) == 12'd0)
                  || (H_Addr == 12'(H_ACTIVE - 1)) || (V_Addr == 12'(V_ACTIVE - 1));

  assign w_in_box = ({1'b0, H_Addr} >= {1'b0, w_box_x})
                 && ({1'b0, H_Addr} <  ({1'b0, w_box_x} + 13'(BOX_SIZE)))
                 && ({1'b0, V_Addr} >= {1'b0, w_box_y})
                 && ({1'b0, V_Addr} <  ({1'b0, w_box_y} + 13'(BOX_SIZE)));

  always_comb begin
    w_pix = RGB_BLACK;
    case (r_mode)
      MODE_BARS: w_pix = bar_color(w_bar_idx);
      MODE_GRID: w_pix = w_grid_on ? RGB_WHITE : RGB_BLACK;
      MODE_RAMP: w_pix = {H_Addr[7:0], H_Addr[7:0], H_Addr[7:0]};
      MODE_BOX:  w_pix = w_in_box ? RGB_RED : RGB_BLUE;
      default:   w_pix = RGB_BLACK;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_disp <= RGB_BLACK;
    else
      r_disp <= Data_Req ? w_pix : RGB_BLACK;
  end

  assign Disp_Data = r_disp;
  assign Mode      = r_mode;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized scoreboard bench for vga_pattern_gen against a frame-level
// reference model (box position as a triangle wave of the frame count).
module tb_vga_pattern_gen;

  localparam int H   = 800;
  localparam int V   = 480;
  localparam int B   = 64;
  localparam int GP  = 32;
  localparam int FPM = 4;

  logic        Clk;
  logic        Reset_n;
  logic        Frame_Start;
  logic        Data_Req;
  logic [11:0] H_Addr;
  logic [11:0] V_Addr;
  logic        Auto_En;
  logic        Mode_Next;
  logic [23:0] Disp_Data;
  logic [1:0]  Mode;

  vga_pattern_gen #(
    .H_ACTIVE        (H),
    .V_ACTIVE        (V),
    .BOX_SIZE        (B),
    .GRID_PITCH      (GP),
    .FRAMES_PER_MODE (FPM)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Frame_Start (Frame_Start),
    .Data_Req    (Data_Req),
    .H_Addr      (H_Addr),
    .V_Addr      (V_Addr),
    .Auto_En     (Auto_En),
    .Mode_Next   (Mode_Next),
    .Disp_Data   (Disp_Data),
    .Mode        (Mode)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q  [$];
  string       name_q [$];
  bit          drv_valid = 0;
  bit          auto_v    = 0;

  // Reference model state
  int m_mode = 0;
  int m_pend = 0;
  int m_cnt  = 0;
  int m_nf   = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic int tri_pos(input int n, input int m);
    int t;
    t = n % (2 * m);
    return (t <= m) ? t : 2 * m - t;
  endfunction

  function automatic int box_x();
    return tri_pos(m_nf, H - B);
  endfunction

  function automatic int box_y();
    return tri_pos(m_nf, V - B);
  endfunction

  function automatic logic [23:0] ref_pix(input int mode, input int h, input int v);
    int idx, bx, by;
    logic [7:0] g;
    bx = box_x();
    by = box_y();
    case (mode)
      0: begin
        idx = h / (H / 8);
        if (idx > 7) idx = 7;
        return bar_tab[idx];
      end
      1: return ((h % GP == 0) || (v % GP == 0) || (h == H - 1) || (v == V - 1)) ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = 8'(h % 256);
        return {g, g, g};
      end
      default: return (bx <= h && h < bx + B && by <= v && v < by + B) ? 24'hFF0000 : 24'h0000FF;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("[TB] ok %s: %h", nm, act);
    end
  endtask

  // One input cycle: expectation uses the pre-edge model state, then the
  // model absorbs any frame/step event of this cycle.
  task automatic cycle(input bit req, input int h, input int v, input bit fs, input bit mn, input string nm);
    int adv;
    @(negedge Clk);
    Data_Req    = req;
    H_Addr      = 12'(h);
    V_Addr      = 12'(v);
    Frame_Start = fs;
    Mode_Next   = mn;
    Auto_En     = auto_v;
    exp_q.push_back(req ? ref_pix(m_mode, h, v) : 24'h0);
    name_q.push_back(nm);
    drv_valid = 1;
    if (fs) begin
      adv = (m_pend != 0) || mn || (auto_v && m_cnt == FPM - 1);
      if (adv != 0) begin
        m_mode = (m_mode + 1) % 4;
        m_cnt  = 0;
      end else begin
        m_cnt = auto_v ? m_cnt + 1 : 0;
      end
      m_pend = 0;
      m_nf++;
    end else begin
      if (mn) m_pend = 1;
      if (!auto_v) m_cnt = 0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, "idle");
  endtask

  task automatic frame(input bit mn);
    cycle(0, 0, 0, 1, mn, "frame");
  endtask

  task automatic check_mode(input string nm);
    idle();
    check(nm, 32'(Mode), 32'(m_mode));
  endtask

  task automatic rand_pixels(input int n, input string nm);
    for (int i = 0; i < n; i++)
      cycle(($urandom_range(0, 4) != 0), $urandom_range(0, H - 1), $urandom_range(0, V - 1), 0, 0, nm);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pend = 0;
    m_cnt  = 0;
    m_nf   = 0;
  endtask

  // Scoreboard monitor: one pop per issued cycle, sampled 1 ns after the edge.
  always @(posedge Clk) begin
    if (drv_valid) begin
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL scoreboard: got %h with no expected entry", Disp_Data);
      end else begin
        check(name_q.pop_front(), 32'(Disp_Data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bx, by;
    Reset_n = 1'b0; Frame_Start = 0; Data_Req = 0; H_Addr = 0; V_Addr = 0;
    Auto_En = 0; Mode_Next = 0;
    #1;
    check("reset_disp", 32'(Disp_Data), 32'h0);
    check("reset_mode", 32'(Mode), 32'h0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // Colour bars
    cycle(1, 0,   0, 0, 0, "bars_0");
    cycle(1, 100, 0, 0, 0, "bars_100");
    cycle(1, 799, 0, 0, 0, "bars_799");
    cycle(1, 99,  7, 0, 0, "bars_99");
    cycle(1, 700, 7, 0, 0, "bars_700");
    check_mode("mode_bars");
    rand_pixels(20, "bars_rand");

    // Manual step mid-frame, applied at the next Frame_Start
    cycle(0, 0, 0, 0, 1, "step");
    check_mode("mode_pending_hold");
    frame(0);
    check_mode("mode_grid");
    cycle(1, 32,  5,   0, 0, "grid_32_5");
    cycle(1, 33,  5,   0, 0, "grid_33_5");
    cycle(1, 799, 5,   0, 0, "grid_799_5");
    cycle(1, 40,  479, 0, 0, "grid_40_479");
    cycle(1, 40,  64,  0, 0, "grid_40_64");
    rand_pixels(20, "grid_rand");

    // Several steps inside one frame advance once
    repeat (3) begin
      cycle(0, 0, 0, 0, 1, "step");
      idle();
    end
    frame(0);
    check_mode("mode_ramp_once");
    cycle(1, 300, 9, 0, 0, "ramp_300");
    cycle(1, 255, 9, 0, 0, "ramp_255");
    rand_pixels(20, "ramp_rand");

    // Step coincident with Frame_Start
    frame(1);
    check_mode("mode_box_coinc");
    frame(0);
    check_mode("mode_box_hold");

    // Auto cycling
    auto_v = 1;
    for (int i = 0; i < 16; i++) begin
      frame(0);
      check_mode($sformatf("auto_f%0d", i + 1));
    end
    auto_v = 0;
    idle();

    // Reach BOX and run the box out to its right edge
    while (m_mode != 3) begin
      frame(1);
      idle();
    end
    check_mode("mode_box");
    while (m_nf < 736) begin
      frame(0);
      if ($urandom_range(0, 31) == 0) begin
        bx = box_x();
        by = box_y();
        cycle(1, bx + $urandom_range(0, B + 2) - 1, by + $urandom_range(0, B + 2) - 1, 0, 0, "box_walk");
      end
    end
    bx = box_x();
    by = box_y();
    cycle(1, bx,         by,         0, 0, "box_tl");
    cycle(1, bx - 1,     by,         0, 0, "box_left_out");
    cycle(1, bx + B - 1, by + B - 1, 0, 0, "box_br");
    cycle(1, bx,         by + B,     0, 0, "box_below_out");
    cycle(1, 736,        416,        0, 0, "box_736_416");
    frame(0);
    bx = box_x();
    by = box_y();
    cycle(1, 735,        by,         0, 0, "box_after_735");
    cycle(1, bx + B,     by,         0, 0, "box_right_out");
    cycle(1, bx + B - 1, by,         0, 0, "box_right_in");
    rand_pixels(20, "box_rand");

    // Data_Req low gives black
    cycle(0, 0,   0, 0, 0, "noreq_0");
    cycle(0, 400, 3, 0, 0, "noreq_400");

    // Asynchronous reset during active video
    cycle(1, 0, 0, 0, 0, "pre_reset");
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    drv_valid = 0;
    check("async_reset_disp", 32'(Disp_Data), 32'h0);
    check("async_reset_mode", 32'(Mode), 32'h0);
    Data_Req = 0; Frame_Start = 0; Mode_Next = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    cycle(1, 0,   0, 0, 0, "post_reset_0");
    cycle(1, 100, 0, 0, 0, "post_reset_100");
    check_mode("post_reset_mode");
    idle();
    @(posedge Clk);
    #2;
    drv_valid = 0;
    @(posedge Clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
